countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter: bit_width, default 64, width of the count and load value.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-high reset; clears all state.
REQ-005 clk_en  input  1  count enable; qualifies decrement only.
REQ-006 load  input  1  capture load_val into count and reload registers.
REQ-007 load_val  input  bit_width  value captured on load.
REQ-008 start  input  1  request IDLE->RUN.
REQ-009 stop  input  1  request RUN->IDLE, count held.
REQ-010 mode  input  1  0 = one-shot, 1 = periodic.
REQ-011 dOUT  output  bit_width  current count register value.
REQ-012 tc  output  1  terminal-count pulse, one clk cycle wide.
REQ-013 busy  output  1  high while state is RUN.
REQ-014 expired  output  1  high while state is EXPIRED.

Function
REQ-015 The FSM SHALL have three states, IDLE, RUN and EXPIRED; busy = (RUN) and expired = (EXPIRED), both registered.
REQ-016 Input priority within a cycle SHALL be load > stop > start > decrement.
REQ-017 load in any state SHALL, next edge: count <= load_val, reload <= load_val, state <= IDLE, tc <= 0.
REQ-018 start in IDLE with count != 0 SHALL enter RUN next edge; start with count == 0, or in RUN or EXPIRED, SHALL be ignored.
REQ-019 stop in RUN SHALL enter IDLE next edge with count unchanged, no decrement, and no tc, even when count == 1 and clk_en = 1.
REQ-020 In RUN with clk_en = 1 and count > 1, count SHALL decrement by 1 per edge; with clk_en = 0, count and state SHALL hold.
REQ-021 In RUN with clk_en = 1 and count == 1 (one-shot): count <= 0, state <= EXPIRED, tc <= 1, all on the same edge.
REQ-022 tc SHALL be registered and SHALL deassert on the following clk edge regardless of clk_en.
REQ-023 Decrement SHALL never occur from count == 0; dOUT SHALL never wrap to all-ones.
REQ-024 EXPIRED SHALL persist until load or rst.
REQ-025 Latency: load or start to observable dOUT/busy change is one clk edge; tc coincides with the edge that produces the terminal value.
REQ-026 The bit_width values 1 through 64 SHALL all be supported, with no truncation of load_val.

Reset
REQ-027 On rst = 1 (asynchronous) the block SHALL force: count = 0, reload = 0, state = IDLE, dOUT = 0, tc = 0, busy = 0, expired = 0.
REQ-028 Reset asserted mid-RUN SHALL abort immediately with no tc; after release, start SHALL be ignored until a load with a nonzero value.

Configuration
REQ-029 Macro COUNTDOWN_TIMER_AUTORELOAD_EN SHALL gate periodic mode.
REQ-030 Macro defined, mode = 1: in RUN with clk_en = 1 and count == 1, count <= reload, state stays RUN, tc <= 1; the period is reload clk_en-qualified cycles.
REQ-031 Macro defined, mode = 0: one-shot behaviour per REQ-021.
REQ-032 Macro undefined: the reload register SHALL be omitted, mode SHALL be ignored (always one-shot), and all ports SHALL remain present.
REQ-033 mode SHALL be sampled at the terminal edge; a change mid-RUN affects only the next expiry.

Verification
REQ-034 Scenario: bit_width = 8, load 5, start, clk_en = 1 continuous -> dOUT 5,4,3,2,1,0; tc high exactly one cycle with dOUT = 0; expired = 1; busy = 0.
REQ-035 Scenario: load 3, start, clk_en toggling 1/0 -> dOUT decrements only on enabled edges; tc appears 3 enabled edges after start.
REQ-036 Scenario: load 4, start, stop at dOUT = 1 with clk_en = 1 -> dOUT stays 1, no tc, IDLE; start -> tc on the next enabled edge.
REQ-037 Scenario: load and start in the same cycle, then load 0 then start -> first starts nothing (IDLE, dOUT = load_val); second stays IDLE with dOUT = 0.
REQ-038 Scenario: rst pulsed mid-RUN at dOUT = 7 -> all outputs 0 asynchronously, no tc, start ignored afterwards.
REQ-039 Scenario: with the macro defined, mode = 1, load 3, start -> dOUT 3,2,1,3,2,1,...; tc every 3rd enabled edge; busy stays 1. Without the macro, the same stimulus -> one-shot, expired = 1.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: the master drives load/start/stop/enable,
// the slave (the timer) returns the count and status flags.
interface countdown_timer_if #(
    parameter int bit_width = 64
);
    logic                 clk_en;
    logic                 load;
    logic [bit_width-1:0] load_val;
    logic                 start;
    logic                 stop;
    logic                 mode;
    logic [bit_width-1:0] dOUT;
    logic                 tc;
    logic                 busy;
    logic                 expired;

    modport master (
        output clk_en, load, load_val, start, stop, mode,
        input  dOUT, tc, busy, expired
    );

    modport slave (
        input  clk_en, load, load_val, start, stop, mode,
        output dOUT, tc, busy, expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/EXPIRED control and a one-cycle terminal-count pulse.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN to add the reload register and periodic mode (mode = 1).
module countdown_timer #(
    parameter int bit_width = 64
) (
    input logic              clk,
    input logic              rst,
    countdown_timer_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_EXPIRED} state_t;

    state_t               state_q, state_d;
    logic [bit_width-1:0] count_q, count_d;
    logic                 tc_q, tc_d;
    logic                 busy_q, busy_d;
    logic                 expired_q, expired_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    logic [bit_width-1:0] reload_q, reload_d;
`else
    logic                 unused_mode;
    assign unused_mode = bus.mode;
`endif

    // Priority: load > stop > start > decrement. Count 0 never decrements.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        reload_d = reload_q;
`endif
        if (bus.load) begin
            count_d = bus.load_val;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_d = bus.load_val;
`endif
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop && count_q != '0) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else if (bus.clk_en && count_q != '0) begin
                        if (count_q != bit_width'(1)) begin
                            count_d = count_q - bit_width'(1);
                        end else begin
                            tc_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
                            if (bus.mode) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = ST_EXPIRED;
                            end
`else
                            count_d = '0;
                            state_d = ST_EXPIRED;
`endif
                        end
                    end
                end
                default: begin
                end
            endcase
        end
        busy_d    = (state_d == ST_RUN);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            tc_q      <= 1'b0;
            busy_q    <= 1'b0;
            expired_q <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            tc_q      <= tc_d;
            busy_q    <= busy_d;
            expired_q <= expired_d;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
            reload_q  <= reload_d;
`endif
        end
    end

    assign bus.dOUT    = count_q;
    assign bus.tc      = tc_q;
    assign bus.busy    = busy_q;
    assign bus.expired = expired_q;
endmodule
